apple_kbd_latch: RTL and testbench

//  Apple II side of the keyboard path: consumes the 8-bit keycode the NIOS drives

---
 rtl/apple_kbd_latch.sv | 144 ++++++++++++++
 tb/tb_apple_kbd_latch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_kbd_latch.sv
// apple_kbd_latch
//   Apple II side of the keyboard path. It watches the keycode byte that the NIOS
//   drives, and detects each 0x00 -> nonzero transition as a new key. New keys are
//   queued in a small FIFO and presented as the Apple II keyboard latch.
//   - $C000-$C00F reads {strobe, key[6:0]}.
//   - Any access to $C010-$C01F clears the strobe and returns {any_key_down, key[6:0]}.
// Ports
//   clk, reset_n  system clock, asynchronous active-low reset
//   keycode       NIOS PIO value (nonzero = key held)
//   bus_addr      Apple II CPU address
//   bus_access    one-clk pulse per CPU bus cycle
//   bus_dout      combinational read data for $C000-$C01F, 0x00 elsewhere
//   kbd_sel       combinational decode of $C000-$C01F
//   key_strobe    latch strobe
//   fifo_count    number of entries queued behind the latch
//   overflow      sticky flag: a key was dropped on a full FIFO
module apple_kbd_latch #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    keycode,
  input  logic [15:0]                   bus_addr,
  input  logic                          bus_access,
  output logic [7:0]                    bus_dout,
  output logic                          kbd_sel,
  output logic                          key_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0] kc_s;

  // Input synchronizer, optionally bypassed
  if (SYNC_STAGES == 0) begin : g_nosync
    assign kc_s = keycode;
  end else begin : g_sync
    logic [7:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
      end else begin
        sync_q[0] <= keycode;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign kc_s = sync_q[SYNC_STAGES-1];
  end

  logic [7:0]       kc_prev_q, kc_prev_d;
  logic             key_strobe_q, key_strobe_d;
  logic [6:0]       latch_q, latch_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [6:0]       mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, new_key, clear, push, drop, pop;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign new_key    = (kc_prev_q == 8'h00) && (kc_s != 8'h00);
  assign clear      = bus_access && (bus_addr[15:4] == 12'hC01);
  assign push       = new_key && !fifo_full;
  assign drop       = new_key && fifo_full;
  // A clear in the same cycle suppresses the load, so the next key loads a clock later
  assign pop        = !key_strobe_q && !fifo_empty && !clear;

  // Next-state logic for FIFO pointers, latch, strobe and flags
  always_comb begin
    kc_prev_d    = kc_s;
    key_strobe_d = key_strobe_q;
    latch_d      = latch_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      latch_d      = mem_q[rd_ptr_q];
      key_strobe_d = 1'b1;
    end
    if (clear) key_strobe_d = 1'b0;
    if (drop)  overflow_d   = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_prev_q    <= 8'h00;
      key_strobe_q <= 1'b0;
      latch_q      <= 7'h00;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 7'h00;
    end else begin
      kc_prev_q    <= kc_prev_d;
      key_strobe_q <= key_strobe_d;
      latch_q      <= latch_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (push) mem_q[wr_ptr_q] <= kc_s[6:0];
    end
  end

  // Address bits [3:0] are don't-care within each 16-byte window
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr[3:0];

  // Read mux: $C01x swaps the strobe bit for the live any-key-down flag
  assign kbd_sel = (bus_addr[15:5] == 11'h600);

  always_comb begin
    bus_dout = 8'h00;
    if (kbd_sel) begin
      if (bus_addr[4]) bus_dout = {(kc_s != 8'h00), latch_q};
      else             bus_dout = {key_strobe_q, latch_q};
    end
  end

  assign key_strobe = key_strobe_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_apple_kbd_latch.sv
// tb_apple_kbd_latch
//   Directed stimulus for apple_kbd_latch, with a queue-based reference model that is
//   checked on every clock. It also includes literal checks on the key scenarios.
module tb_apple_kbd_latch;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    keycode = 8'h00;
  logic [15:0]   bus_addr = 16'h0000;
  logic          bus_access = 1'b0;
  logic [7:0]    bus_dout;
  logic          kbd_sel;
  logic          key_strobe;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  apple_kbd_latch #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .bus_addr   (bus_addr),
    .bus_access (bus_access),
    .bus_dout   (bus_dout),
    .kbd_sel    (kbd_sel),
    .key_strobe (key_strobe),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending keys plus latch/strobe/overflow
  logic [7:0] m_q[$];
  logic [7:0] m_pipe[$];
  logic [7:0] m_prev = 8'h00;
  logic [6:0] m_latch = 7'h00;
  logic       m_strobe = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_ks;
  bit         m_clr, m_new, m_pop;
  int         m_sz;

  function automatic logic [7:0] m_kc_s();
    if (SYNC == 0) return keycode;
    return m_pipe[0];
  endfunction

  function automatic logic [7:0] exp_dout();
    logic [7:0] ks;
    ks = m_kc_s();
    if (bus_addr[15:5] != 11'h600) return 8'h00;
    if (bus_addr[4]) return {(ks != 8'h00), m_latch};
    return {m_strobe, m_latch};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(8'h00);
      m_prev   = 8'h00;
      m_latch  = 7'h00;
      m_strobe = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_ks  = m_kc_s();
      m_clr = bus_access && (bus_addr >= 16'hC010) && (bus_addr <= 16'hC01F);
      m_new = (m_prev == 8'h00) && (m_ks != 8'h00);
      m_sz  = m_q.size();
      m_pop = !m_strobe && (m_sz > 0) && !m_clr;
      if (m_pop) begin
        m_latch  = m_q.pop_front() & 8'h7F;
        m_strobe = 1'b1;
      end
      if (m_new) begin
        if (m_sz < DEPTH) m_q.push_back(m_ks);
        else              m_ovf = 1'b1;
      end
      if (m_clr) m_strobe = 1'b0;
      m_prev = m_ks;
      if (SYNC > 0) begin
        m_pipe.push_back(keycode);
        void'(m_pipe.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("strobe", 32'(key_strobe), 32'(m_strobe));
    chk("count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("kbd_sel", 32'(kbd_sel), 32'((bus_addr >= 16'hC000) && (bus_addr <= 16'hC01F)));
    chk("dout", 32'(bus_dout), 32'(exp_dout()));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic type_key(input logic [7:0] k);
    keycode = k;
    cyc(3);
    keycode = 8'h00;
    cyc(3);
  endtask

  task automatic clear_strobe();
    bus_addr   = 16'hC010;
    bus_access = 1'b1;
    cyc(1);
    bus_access = 1'b0;
    cyc(1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
    bus_addr = a;
    #1;
    chk(nm, 32'(bus_dout), 32'(e));
  endtask

  initial begin
    logic [7:0] k;
    // Reset state
    cyc(3);
    chk("rst_strobe", 32'(key_strobe), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rd(16'hC000, 8'h00, "rst_c000");
    reset_n = 1'b1;

    // 1: first key, latency SYNC+2
    keycode = 8'hC1;
    cyc(SYNC + 1);
    chk("t1_strobe_early", 32'(key_strobe), 32'd0);
    cyc(1);
    chk("t1_strobe", 32'(key_strobe), 32'd1);
    rd(16'hC000, 8'hC1, "t1_c000");
    chk("t1_count", 32'(fifo_count), 32'd0);
    cyc(6);

    // 2: clear via $C010 while key held, then release
    bus_addr   = 16'hC010;
    bus_access = 1'b1;
    #1;
    chk("t2_c010_held", 32'(bus_dout), 32'hC1);
    cyc(1);
    bus_access = 1'b0;
    chk("t2_strobe_clr", 32'(key_strobe), 32'd0);
    keycode = 8'h00;
    cyc(3);
    rd(16'hC010, 8'h41, "t2_c010_rel");
    rd(16'hC000, 8'h41, "t2_c000");

    // 3: three keys queued, drained by clears
    type_key(8'hC1);
    type_key(8'hC2);
    type_key(8'hC3);
    cyc(2);
    chk("t3_count", 32'(fifo_count), 32'd2);
    rd(16'hC000, 8'hC1, "t3_A");
    clear_strobe();
    rd(16'hC000, 8'hC2, "t3_B");
    chk("t3_count_b", 32'(fifo_count), 32'd1);
    clear_strobe();
    rd(16'hC000, 8'hC3, "t3_C");
    chk("t3_count_c", 32'(fifo_count), 32'd0);
    clear_strobe();
    chk("t3_strobe_end", 32'(key_strobe), 32'd0);
    rd(16'hC000, 8'h43, "t3_c000_end");

    // 4: overflow with DEPTH+2 keys
    for (int i = 0; i < DEPTH + 2; i++) begin
      k = 8'hC4 + 8'(i);
      type_key(k);
    end
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'(DEPTH));
    rd(16'hC000, 8'hC4, "t4_first");
    for (int i = 1; i <= DEPTH; i++) begin
      clear_strobe();
      k = 8'hC4 + 8'(i);
      rd(16'hC000, k, "t4_drain");
    end
    clear_strobe();
    chk("t4_strobe_end", 32'(key_strobe), 32'd0);
    chk("t4_count_end", 32'(fifo_count), 32'd0);

    // 5: nonzero->nonzero change is not a new key
    keycode = 8'h41;
    cyc(3);
    keycode = 8'h42;
    cyc(3);
    keycode = 8'h00;
    cyc(3);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_strobe", 32'(key_strobe), 32'd1);
    rd(16'hC000, 8'hC1, "t5_c000");
    clear_strobe();
    chk("t5_strobe_clr", 32'(key_strobe), 32'd0);
    chk("t5_count_end", 32'(fifo_count), 32'd0);

    // 6: reset mid-operation, then key held through release
    type_key(8'hC1);
    type_key(8'hC2);
    type_key(8'hC3);
    chk("t6_pre_strobe", 32'(key_strobe), 32'd1);
    chk("t6_pre_count", 32'(fifo_count), 32'd2);
    reset_n = 1'b0;
    keycode = 8'hC5;
    #1;
    chk("t6_strobe", 32'(key_strobe), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    rd(16'hC000, 8'h00, "t6_c000");
    rd(16'hC020, 8'h00, "t6_c020");
    chk("t6_sel_c020", 32'(kbd_sel), 32'd0);
    rd(16'hC01F, 8'h00, "t6_c01f");
    chk("t6_sel_c01f", 32'(kbd_sel), 32'd1);
    rd(16'hBFFF, 8'h00, "t6_bfff");
    chk("t6_sel_bfff", 32'(kbd_sel), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(SYNC + 1);
    chk("t6_held_early", 32'(key_strobe), 32'd0);
    cyc(1);
    chk("t6_held_key", 32'(key_strobe), 32'd1);
    rd(16'hC000, 8'hC5, "t6_held_c000");
    keycode = 8'h00;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
